// File: rtl/led_pkg.sv
// Shared types and defaults for the LED PWM controller.
package led_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ON      = 2'd1,
    BLINK   = 2'd2,
    BREATHE = 2'd3
  } led_mode_t;

  localparam int NUM_CH_DEF      = 3;
  localparam int PWM_W_DEF       = 8;
  localparam int CLK_DIV_DEF     = 12000;
  localparam int BLINK_TICKS_DEF = 250;
  localparam bit ACTIVE_LOW_DEF  = 1'b1;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Animation prescaler: one-cycle tick every CLK_DIV clk cycles.
module led_tick_gen #(
  parameter int CLK_DIV = 12000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == CW'(CLK_DIV - 1));

  // Count 0..CLK_DIV-1; tick is decoded from the terminal count.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM controller with OFF/ON/BLINK/BREATHE modes.
// Configuration writes are staged in one pending register and applied at
// the PWM period boundary so a channel never changes mid-period.
module led_pwm_ctrl
  import led_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int PWM_W       = PWM_W_DEF,
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int BLINK_TICKS = BLINK_TICKS_DEF,
  parameter bit ACTIVE_LOW  = ACTIVE_LOW_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
  input  logic [1:0]                    cfg_mode,
  input  logic [PWM_W-1:0]              cfg_level,
  output logic [NUM_CH-1:0]             led
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam int BW   = $clog2(BLINK_TICKS + 1);

  logic [PWM_W-1:0] pwm_cnt;
  logic             tick;
  logic             wrap;
  logic             accept;
  logic             apply;

  logic             pend_valid;
  logic [CH_W-1:0]  pend_ch;
  led_mode_t        pend_mode;
  logic [PWM_W-1:0] pend_level;

  logic [BW-1:0]    blink_cnt;
  logic             blink_phase;

  led_mode_t        mode_q   [NUM_CH];
  logic [PWM_W-1:0] level_q  [NUM_CH];
  logic [PWM_W-1:0] bright_q [NUM_CH];
  logic [NUM_CH-1:0] dir_up;
  logic [PWM_W-1:0] duty     [NUM_CH];

  assign wrap   = &pwm_cnt;
  assign accept = cfg_valid & cfg_ready;
  assign apply  = pend_valid & wrap;

  led_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Free-running PWM period counter shared by all channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Single-entry write buffer; ready drops on accept and returns on apply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_mode  <= OFF;
      pend_level <= '0;
      cfg_ready  <= 1'b0;
    end else begin
      if (apply) pend_valid <= 1'b0;
      if (accept) begin
        pend_valid <= 1'b1;
        pend_ch    <= cfg_ch;
        pend_mode  <= led_mode_t'(cfg_mode);
        pend_level <= cfg_level;
      end
      cfg_ready <= ~(accept | (pend_valid & ~apply));
    end
  end

  // Global blink phase toggles every BLINK_TICKS ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Per-channel config and breathe animation; an apply restarts the ramp.
  // NOTE: the channel arrays are reset explicitly because all modes must read OFF out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]   <= OFF;
        level_q[i]  <= '0;
        bright_q[i] <= '0;
        dir_up[i]   <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (apply && pend_ch == CH_W'(i)) begin
          mode_q[i]   <= pend_mode;
          level_q[i]  <= pend_level;
          bright_q[i] <= '0;
          dir_up[i]   <= 1'b1;
        end else if (tick && mode_q[i] == BREATHE) begin
          if (dir_up[i]) begin
            if (bright_q[i] < level_q[i]) begin
              bright_q[i] <= bright_q[i] + 1'b1;
              if (bright_q[i] == level_q[i] - 1'b1) dir_up[i] <= 1'b0;
            end else begin
              dir_up[i] <= 1'b0;
            end
          end else begin
            if (bright_q[i] != '0) bright_q[i] <= bright_q[i] - 1'b1;
            if (bright_q[i] <= PWM_W'(1)) dir_up[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Duty selection by mode.
  // NOTE: duty gets a default before the case so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      duty[i] = '0;
      case (mode_q[i])
        ON:      duty[i] = level_q[i];
        BLINK:   duty[i] = blink_phase ? level_q[i] : '0;
        BREATHE: duty[i] = bright_q[i];
        default: duty[i] = '0;
      endcase
    end
  end

  // Registered LED drive: lit while pwm_cnt < duty, polarity per ACTIVE_LOW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= {NUM_CH{ACTIVE_LOW}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        led[i] <= (pwm_cnt < duty[i]) ^ ACTIVE_LOW;
      end
    end
  end

endmodule

// File: doc/led_pwm_ctrl.md
LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3: number of LED channels, 1..16.
REQ-002 Parameter PWM_W, default 8: duty/level width; PWM period = 2^PWM_W clk cycles.
REQ-003 Parameter CLK_DIV, default 12000: clk cycles per animation tick, >= 2.
REQ-004 Parameter BLINK_TICKS, default 250: ticks per blink half-period, >= 1.
REQ-005 Parameter ACTIVE_LOW, default 1: 1 = common-anode LEDs, so a lit LED is driven 0.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 cfg_valid  input  1  configuration write request.
REQ-009 cfg_ready  output  1  configuration write can be accepted.
REQ-010 cfg_ch  input  max(1,$clog2(NUM_CH))  target channel.
REQ-011 cfg_mode  input  2  OFF=0, ON=1, BLINK=2, BREATHE=3.
REQ-012 cfg_level  input  PWM_W  brightness level.
REQ-013 led  output  NUM_CH  registered LED drive, one bit per channel.

Function
REQ-014 A write is accepted on an edge where cfg_valid and cfg_ready are both 1; cfg_ch, cfg_mode and cfg_level are captured into a single pending register.
REQ-015 cfg_ready shall be 0 from acceptance until the pending write is applied, and 1 otherwise.
REQ-016 pwm_cnt is a free-running PWM_W-bit counter that increments every clk and wraps from all-ones to 0.
REQ-017 A pending write is applied on the edge where pwm_cnt wraps to 0; cfg_ready returns to 1 on that same edge.
REQ-018 A write accepted on the wrap edge itself is applied at the following wrap.
REQ-019 A write with cfg_ch >= NUM_CH is accepted, then released at the next wrap with no state change.
REQ-020 Apply updates the channel's mode and level, and also restarts animation: breathe brightness goes to 0 and direction goes to up.
REQ-021 The tick generator pulses tick for one cycle every CLK_DIV clk cycles.
REQ-022 blink_phase is a single global bit; it starts at 1 and toggles after every BLINK_TICKS ticks.
REQ-023 Per-channel duty by mode:
- OFF: 0.
- ON: level.
- BLINK: level when blink_phase = 1, else 0.
- BREATHE: brightness.
REQ-024 In BREATHE, each tick moves brightness one step toward level (when direction is up) or toward 0 (when direction is down); direction reverses on reaching the limit. Level 0 holds brightness at 0.
REQ-025 A channel is lit while pwm_cnt < duty, so duty 0 is never lit and all-ones is lit 2^PWM_W-1 of 2^PWM_W cycles.
REQ-026 led[i] is registered one cycle after the compare and equals lit XOR ACTIVE_LOW.

Reset
REQ-027 While rst = 1: led equals all ACTIVE_LOW, cfg_ready = 0, and every register is cleared (all modes OFF, levels 0, pwm_cnt 0, prescaler 0, pending register empty, blink_phase 1).
REQ-028 cfg_ready shall be 1 on the first edge after rst deasserts.
REQ-029 Reset asserted mid-operation discards any pending write.

Structure
REQ-030 Shared package led_pkg shall hold the led_mode_t enum (OFF, ON, BLINK, BREATHE) and the parameter defaults.
REQ-031 Sub-module led_tick_gen (parameter CLK_DIV; ports clk, rst, tick) shall contain the prescaler.
REQ-032 Per-channel state shall be held in arrays sized by NUM_CH; all channels share one pwm_cnt and one tick.

Verification (NUM_CH=3, PWM_W=4, CLK_DIV=4, BLINK_TICKS=2, ACTIVE_LOW=1)
REQ-033 Assert rst mid-BLINK -> led=3'b111 and cfg_ready=0 immediately; after release, cfg_ready=1 on the next edge.
REQ-034 Write ch0 ON level 4 -> from the first wrap after acceptance, led[0]=0 for exactly 4 of every 16 cycles.
REQ-035 Issue two back-to-back writes -> the second stalls with cfg_ready=0 until the wrap that applies the first, then is accepted.
REQ-036 Write ch1 BLINK level 15 -> led[1] PWM-active and dark in alternating 8-cycle windows (BLINK_TICKS x CLK_DIV).
REQ-037 Write ch2 BREATHE level 3 -> per-tick brightness follows 0,1,2,3,2,1,0,1.
REQ-038 Write cfg_ch=3 -> handshake completes at the next wrap and led is unchanged.
